loop_addr_seq: RTL and testbench
================================

Name: loop_addr_seq

Overview:
- Address/access sequencer for the 8-bank looper; sits directly upstream of the memory controller and the Ram2Ddr RAM-style interface.
- On every 44.1 kHz sample tick it issues 8 accesses, one per bank, at address {0, block, bank}.
- Manages block advance, loop length (max_block), wrap-around, the per-bank active map, and bank deletion by zero-fill.

Parameters:
- BLOCK_W, 23, block counter width.
- BANK_W, 3, bank index width (8 banks).
- MAX_BLOCKS, 8000000, hard limit on loop length in blocks.

Ports:
- clk_100MHz  in  1  system clock (100 MHz clk_wiz output)
- rstn  in  1  synchronous, active-low reset
- sample_tick  in  1  one-cycle strobe at 44.1 kHz
- playing  in  1  level: play mode
- recording  in  1  level: record mode
- rec_bank  in  3  bank recorded while recording=1
- del_req  in  1  level: request to delete del_bank
- del_bank  in  3  bank to delete
- mem_ack  in  1  one-cycle pulse: current access complete
- mem_req  out  1  access request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_a  out  27  {1'b0, current_block, bank}
- write_zero  out  1  high during delete-fill writes
- current_bank  out  3  bank of the in-flight access
- current_block  out  23  block pointer
- max_block  out  23  loop length; 0 = unset
- active  out  8  bank holds a recording
- del_done  out  1  one-cycle pulse when a delete finishes
- overrun  out  1  sticky: a tick arrived while a sweep was in progress

Behaviour:
- Reset (rstn=0 at a clock edge): all outputs 0, FSM goes to IDLE, overrun is cleared. Any in-flight request is abandoned; mem_req=0 the cycle after the reset edge.
- FSM states: IDLE, SWEEP, GAP, DEL, DEL_GAP.
- IDLE -> SWEEP: on sample_tick with (playing | recording).
  - bank=0; mem_req=1 the next cycle.
- SWEEP:
  - mem_we = recording & (bank == rec_bank); all other banks are reads.
  - mem_a, mem_we and write_zero are stable while mem_req=1.
  - On mem_ack: mem_req=0 the next cycle (GAP, exactly 1 cycle low).
  - If bank<7: bank+1, return to SWEEP.
  - If bank==7: advance the block, go to IDLE.
- Block advance:
  - If max_block != 0: current_block = (current_block == max_block-1) ? 0 : +1.
  - If max_block == 0 (first take): +1. On reaching MAX_BLOCKS-1, treat it as the end of the first take.
- First take end (falling edge of recording while max_block==0, or limit reached):
  - max_block <= current_block+1, current_block <= 0.
  - If the take ended with current_block==0 and no write was completed, max_block stays 0.
- active[rec_bank] is set on completion of the first write to that bank.
- sample_tick outside IDLE: the tick is dropped and overrun<=1. overrun clears only on reset.
- IDLE -> DEL: when del_req=1, playing=0, recording=0 and active[del_bank]=1.
  - If del_req arrives with active[del_bank]=0: pulse del_done immediately, no writes.
  - del_req is ignored while playing or recording. Priority in IDLE: sample_tick > del_req.
- DEL: one write per block to del_bank, blocks 0..max_block-1, with mem_we=1 and write_zero=1. Each write is followed by a 1-cycle DEL_GAP.
- DEL complete (last block acked):
  - clear active[del_bank]; if the result is active==0, max_block<=0.
  - current_block<=0, del_done=1 for one cycle, go to IDLE.
- Sample ticks during DEL are dropped and set overrun.
- mem_ack while mem_req=0 is ignored.

Decomposition:
- Package looper_pkg holds:
  - BLOCK_W, BANK_W, NUM_BANKS=8, MAX_BLOCKS
  - the FSM state enum
  - the address-pack function {1'b0, block, bank}
- One natural sub-module: loop_len_ctrl, which owns current_block, max_block, the first-take/wrap logic and the active map.
- The FSM and handshake stay in the top of loop_addr_seq.

Test Plan:
- Reset mid-sweep (bank 3 outstanding) -> mem_req=0 the next cycle; all outputs 0; the next tick starts at bank 0, block 0.
- First take: rec_bank=2, recording for 5 ticks then low.
  - 40 accesses; only bank 2 has mem_we=1 (mem_a=...010).
  - max_block=5, active=8'h04, current_block=0.
- Playback wrap with max_block=5: 6 ticks -> blocks 0,1,2,3,4,0; mem_a of the 6th tick's first access = 27'd0.
- Overrun: a second tick arrives during bank 4 of a sweep -> overrun=1; sweep completes normally; exactly 8 accesses.
- Delete bank 2 (max_block=5, only bank active):
  - 5 writes with write_zero=1 at mem_a = 2, 10, 18, 26, 34.
  - then del_done pulse; active=0, max_block=0.
- Delete an inactive bank 6 -> del_done the next cycle, zero mem_req pulses; del_req while playing -> no effect.

Source files
------------

// File: rtl/looper_pkg.sv
// Shared widths, FSM state encoding and address packing for the 8-bank looper sequencer.
package looper_pkg;

    localparam int unsigned BLOCK_W    = 23;
    localparam int unsigned BANK_W     = 3;
    localparam int unsigned NUM_BANKS  = 8;
    localparam int unsigned MAX_BLOCKS = 8000000;
    localparam int unsigned ADDR_W     = 1 + BLOCK_W + BANK_W;

    typedef enum logic [2:0] {
        StIdle,
        StSweep,
        StGap,
        StDel,
        StDelGap
    } seq_state_e;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [BLOCK_W-1:0] block,
                                                     input logic [BANK_W-1:0]  bank);
        return {1'b0, block, bank};
    endfunction

endpackage

// File: rtl/loop_len_ctrl.sv
// Block pointer, loop length and active-bank map: first-take sizing, wrap-around and
// the bookkeeping side of bank deletion.
module loop_len_ctrl
    import looper_pkg::*;
#(
    parameter int unsigned MaxBlocks = MAX_BLOCKS
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 idle_i,
    input  logic                 recording_i,
    input  logic                 advance_i,
    input  logic                 wr_done_i,
    input  logic [BANK_W-1:0]    wr_bank_i,
    input  logic                 del_start_i,
    input  logic                 del_step_i,
    input  logic                 del_fin_i,
    input  logic [BANK_W-1:0]    del_bank_i,
    output logic [BLOCK_W-1:0]   cur_block_o,
    output logic [BLOCK_W-1:0]   max_block_o,
    output logic [NUM_BANKS-1:0] active_o,
    output logic                 del_last_o
);

    localparam logic [BLOCK_W-1:0] LastBlk  = BLOCK_W'(MaxBlocks - 1);
    localparam logic [BLOCK_W-1:0] LimitLen = BLOCK_W'(MaxBlocks);
    localparam logic [BLOCK_W-1:0] One      = BLOCK_W'(1);

    logic [BLOCK_W-1:0]   cur_q, cur_d, max_q, max_d;
    logic [NUM_BANKS-1:0] act_q, act_d;
    logic                 rec_q, pend_q, pend_d;
    logic                 rec_fall, take_end;

    // A take that ends mid-sweep is held pending so mem_a never moves under a live request.
    assign rec_fall = rec_q & ~recording_i;
    assign take_end = (pend_q | rec_fall) & (max_q == '0) & idle_i;
    assign pend_d   = (pend_q | rec_fall) & (max_q == '0) & ~idle_i;

    always_comb begin
        cur_d = cur_q;
        max_d = max_q;
        act_d = act_q;
        if (wr_done_i) begin
            act_d[wr_bank_i] = 1'b1;
        end
        if (advance_i) begin
            if (max_q != '0) begin
                cur_d = (cur_q == max_q - One) ? '0 : cur_q + One;
            end else if (cur_q == LastBlk) begin
                max_d = LimitLen;
                cur_d = '0;
            end else begin
                cur_d = cur_q + One;
            end
        end
        // After the sweep has advanced, cur_q counts the blocks written; zero leaves max unset.
        if (take_end) begin
            max_d = cur_q;
            cur_d = '0;
        end
        if (del_start_i) begin
            cur_d = '0;
        end
        if (del_step_i) begin
            cur_d = cur_q + One;
        end
        if (del_fin_i) begin
            act_d[del_bank_i] = 1'b0;
            cur_d             = '0;
            if (act_d == '0) begin
                max_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cur_q  <= '0;
            max_q  <= '0;
            act_q  <= '0;
            rec_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cur_q  <= cur_d;
            max_q  <= max_d;
            act_q  <= act_d;
            rec_q  <= recording_i;
            pend_q <= pend_d;
        end
    end

    assign cur_block_o = cur_q;
    assign max_block_o = max_q;
    assign active_o    = act_q;
    assign del_last_o  = (max_q == '0) || (cur_q == max_q - One);

endmodule

// File: rtl/loop_addr_seq.sv
// Per-tick 8-bank access sequencer and delete-by-zero-fill engine in front of the
// memory controller; request/ack handshake with a one-cycle gap between accesses.
module loop_addr_seq
    import looper_pkg::*;
(
    input  logic                 clk_100MHz,
    input  logic                 rstn,
    input  logic                 sample_tick,
    input  logic                 playing,
    input  logic                 recording,
    input  logic [BANK_W-1:0]    rec_bank,
    input  logic                 del_req,
    input  logic [BANK_W-1:0]    del_bank,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_a,
    output logic                 write_zero,
    output logic [BANK_W-1:0]    current_bank,
    output logic [BLOCK_W-1:0]   current_block,
    output logic [BLOCK_W-1:0]   max_block,
    output logic [NUM_BANKS-1:0] active,
    output logic                 del_done,
    output logic                 overrun
);

    localparam logic [BANK_W-1:0] LastBank = BANK_W'(NUM_BANKS - 1);

    seq_state_e        state_q, state_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              we_q, we_d, wz_q, wz_d;
    logic              done_q, done_d, ovr_q, ovr_d;
    logic              advance, wr_done, del_start, del_step, del_fin, del_last;

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        we_d      = we_q;
        wz_d      = wz_q;
        done_d    = 1'b0;
        ovr_d     = ovr_q | (sample_tick & (state_q != StIdle));
        advance   = 1'b0;
        wr_done   = 1'b0;
        del_start = 1'b0;
        del_step  = 1'b0;
        del_fin   = 1'b0;
        case (state_q)
            StIdle: begin
                if (sample_tick && (playing || recording)) begin
                    state_d = StSweep;
                    bank_d  = '0;
                    we_d    = recording && (rec_bank == '0);
                    wz_d    = 1'b0;
                end else if (del_req && !playing && !recording) begin
                    if (active[del_bank]) begin
                        state_d   = StDel;
                        bank_d    = del_bank;
                        del_start = 1'b1;
                        we_d      = 1'b1;
                        wz_d      = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StSweep: begin
                if (mem_ack) begin
                    we_d    = 1'b0;
                    wr_done = we_q;
                    if (bank_q == LastBank) begin
                        advance = 1'b1;
                        state_d = StIdle;
                    end else begin
                        bank_d  = bank_q + BANK_W'(1);
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                state_d = StSweep;
                we_d    = recording && (bank_q == rec_bank);
            end
            StDel: begin
                if (mem_ack) begin
                    we_d = 1'b0;
                    wz_d = 1'b0;
                    if (del_last) begin
                        del_fin = 1'b1;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        del_step = 1'b1;
                        state_d  = StDelGap;
                    end
                end
            end
            StDelGap: begin
                state_d = StDel;
                we_d    = 1'b1;
                wz_d    = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (!rstn) begin
            state_q <= StIdle;
            bank_q  <= '0;
            we_q    <= 1'b0;
            wz_q    <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            we_q    <= we_d;
            wz_q    <= wz_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    loop_len_ctrl #(
        .MaxBlocks (MAX_BLOCKS)
    ) u_len_ctrl (
        .clk_i       (clk_100MHz),
        .rst_ni      (rstn),
        .idle_i      (state_q == StIdle),
        .recording_i (recording),
        .advance_i   (advance),
        .wr_done_i   (wr_done),
        .wr_bank_i   (bank_q),
        .del_start_i (del_start),
        .del_step_i  (del_step),
        .del_fin_i   (del_fin),
        .del_bank_i  (bank_q),
        .cur_block_o (current_block),
        .max_block_o (max_block),
        .active_o    (active),
        .del_last_o  (del_last)
    );

    assign mem_req      = (state_q == StSweep) || (state_q == StDel);
    assign mem_we       = we_q;
    assign write_zero   = wz_q;
    assign mem_a        = pack_addr(current_block, bank_q);
    assign current_bank = bank_q;
    assign del_done     = done_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_loop_addr_seq.sv
// Scoreboard bench for loop_addr_seq: expected accesses are queued as ticks/deletes are
// issued and checked as a responder acknowledges each request.
module tb_loop_addr_seq;

    logic        clk_100MHz = 1'b0;
    logic        rstn, sample_tick, playing, recording, del_req, mem_ack;
    logic [2:0]  rec_bank, del_bank;
    logic        mem_req, mem_we, write_zero, del_done, overrun;
    logic [26:0] mem_a;
    logic [2:0]  current_bank;
    logic [22:0] current_block, max_block;
    logic [7:0]  active;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [26:0] a;
        logic        we;
        logic        wz;
    } acc_t;

    acc_t exp_q[$];

    always #5 clk_100MHz = ~clk_100MHz;

    loop_addr_seq dut (
        .clk_100MHz    (clk_100MHz),
        .rstn          (rstn),
        .sample_tick   (sample_tick),
        .playing       (playing),
        .recording     (recording),
        .rec_bank      (rec_bank),
        .del_req       (del_req),
        .del_bank      (del_bank),
        .mem_ack       (mem_ack),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_a         (mem_a),
        .write_zero    (write_zero),
        .current_bank  (current_bank),
        .current_block (current_block),
        .max_block     (max_block),
        .active        (active),
        .del_done      (del_done),
        .overrun       (overrun)
    );

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        step();
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    // Expected sweep: address = block*8 + bank, only wbank written.
    task automatic push_sweep(input int blk, input int wbank);
        for (int b = 0; b < 8; b++) begin
            acc_t e;
            e.a  = 27'(blk * 8 + b);
            e.we = (b == wbank);
            e.wz = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic serve(input int n);
        for (int i = 0; i < n; i++) begin
            acc_t e;
            int   w;
            w = 0;
            while (mem_req !== 1'b1 && w < 50) begin
                step();
                w++;
            end
            checks++;
            if (mem_req !== 1'b1) begin
                failures++;
                $display("FAIL access_timeout: mem_req=%b after %0d cycles, required 1", mem_req, w);
                return;
            end
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_access: mem_a=%0d, required no access", mem_a);
                return;
            end
            e = exp_q.pop_front();
            if (mem_a !== e.a || mem_we !== e.we || write_zero !== e.wz) begin
                failures++;
                $display("FAIL access: a=%0d we=%b wz=%b, required a=%0d we=%b wz=%b",
                         mem_a, mem_we, write_zero, e.a, e.we, e.wz);
            end
            repeat (i % 3) step();
            checks++;
            if (mem_req !== 1'b1 || mem_a !== e.a || mem_we !== e.we || write_zero !== e.wz) begin
                failures++;
                $display("FAIL access_hold: req=%b a=%0d we=%b, required req=1 a=%0d we=%b",
                         mem_req, mem_a, mem_we, e.a, e.we);
            end
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            checks++;
            if (mem_req !== 1'b0) begin
                failures++;
                $display("FAIL access_gap: mem_req=%b after ack, required 0", mem_req);
            end
        end
    endtask

    task automatic test_reset();
        logic [88:0] v;
        apply_reset();
        v = {mem_req, mem_we, mem_a, write_zero, current_bank, current_block, max_block,
             active, del_done, overrun};
        checks++;
        if (v !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h, required 0", v);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [88:0] v;
        int          w;
        playing = 1'b1;
        push_sweep(0, -1);
        pulse_tick();
        serve(3);
        w = 0;
        while (mem_req !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        checks++;
        if (current_bank !== 3'd3 || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_sweep_bank: bank=%0d req=%b, required bank=3 req=1",
                     current_bank, mem_req);
        end
        rstn = 1'b0;
        step();
        v = {mem_req, mem_we, mem_a, write_zero, current_bank, current_block, max_block,
             active, del_done, overrun};
        checks++;
        if (v !== '0) begin
            failures++;
            $display("FAIL reset_mid_sweep: got %h, required 0", v);
        end
        rstn = 1'b1;
        exp_q.delete();
        step();
        push_sweep(0, -1);
        pulse_tick();
        serve(8);
        playing = 1'b0;
        checks++;
        if (current_block !== 23'd1) begin
            failures++;
            $display("FAIL post_reset_block: current_block=%0d, required 1", current_block);
        end
    endtask

    task automatic test_first_take();
        apply_reset();
        rec_bank  = 3'd2;
        recording = 1'b1;
        for (int t = 0; t < 5; t++) begin
            push_sweep(t, 2);
            pulse_tick();
            serve(8);
            if (t == 0) begin
                checks++;
                if (active !== 8'h04) begin
                    failures++;
                    $display("FAIL active_first_write: active=%h, required 04", active);
                end
            end
        end
        recording = 1'b0;
        repeat (2) step();
        checks++;
        if (max_block !== 23'd5 || active !== 8'h04 || current_block !== 23'd0) begin
            failures++;
            $display("FAIL first_take_end: max=%0d active=%h cur=%0d, required max=5 active=04 cur=0",
                     max_block, active, current_block);
        end
    endtask

    task automatic test_playback_wrap();
        int blks[6] = '{0, 1, 2, 3, 4, 0};
        playing = 1'b1;
        for (int t = 0; t < 6; t++) begin
            push_sweep(blks[t], -1);
            pulse_tick();
            serve(8);
        end
        playing = 1'b0;
        checks++;
        if (current_block !== 23'd1 || max_block !== 23'd5) begin
            failures++;
            $display("FAIL wrap_pointer: cur=%0d max=%0d, required cur=1 max=5",
                     current_block, max_block);
        end
    endtask

    task automatic test_overrun();
        int w;
        int seen;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_initial: overrun=%b, required 0", overrun);
        end
        playing = 1'b1;
        push_sweep(1, -1);
        pulse_tick();
        serve(4);
        w = 0;
        while (mem_req !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        pulse_tick();
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: overrun=%b, required 1", overrun);
        end
        serve(4);
        seen = 0;
        repeat (20) begin
            step();
            if (mem_req === 1'b1) seen++;
        end
        playing = 1'b0;
        checks++;
        if (seen != 0 || exp_q.size() != 0 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_extra: req_cycles=%0d pending=%0d overrun=%b, required 0 0 1",
                     seen, exp_q.size(), overrun);
        end
    endtask

    task automatic test_delete();
        for (int b = 0; b < 5; b++) begin
            acc_t e;
            e.a  = 27'(b * 8 + 2);
            e.we = 1'b1;
            e.wz = 1'b1;
            exp_q.push_back(e);
        end
        del_bank = 3'd2;
        del_req  = 1'b1;
        step();
        del_req = 1'b0;
        serve(5);
        checks++;
        if (del_done !== 1'b1) begin
            failures++;
            $display("FAIL del_done_pulse: del_done=%b, required 1", del_done);
        end
        step();
        checks++;
        if (del_done !== 1'b0 || active !== 8'h00 || max_block !== 23'd0 ||
            current_block !== 23'd0) begin
            failures++;
            $display("FAIL delete_result: done=%b active=%h max=%0d cur=%0d, required 0 00 0 0",
                     del_done, active, max_block, current_block);
        end
    endtask

    task automatic test_delete_inactive();
        int reqs;
        int dones;
        del_bank = 3'd6;
        del_req  = 1'b1;
        step();
        del_req = 1'b0;
        checks++;
        if (del_done !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL del_inactive: done=%b req=%b, required done=1 req=0", del_done, mem_req);
        end
        reqs  = 0;
        dones = 0;
        repeat (10) begin
            step();
            if (mem_req === 1'b1) reqs++;
            if (del_done === 1'b1) dones++;
        end
        checks++;
        if (reqs != 0 || dones != 0) begin
            failures++;
            $display("FAIL del_inactive_quiet: req_cycles=%0d done_cycles=%0d, required 0 0",
                     reqs, dones);
        end
        playing = 1'b1;
        del_req = 1'b1;
        reqs    = 0;
        dones   = 0;
        repeat (6) begin
            step();
            if (mem_req === 1'b1) reqs++;
            if (del_done === 1'b1) dones++;
        end
        del_req = 1'b0;
        playing = 1'b0;
        checks++;
        if (reqs != 0 || dones != 0) begin
            failures++;
            $display("FAIL del_while_playing: req_cycles=%0d done_cycles=%0d, required 0 0",
                     reqs, dones);
        end
    endtask

    initial begin
        rstn        = 1'b0;
        sample_tick = 1'b0;
        playing     = 1'b0;
        recording   = 1'b0;
        rec_bank    = 3'd0;
        del_req     = 1'b0;
        del_bank    = 3'd0;
        mem_ack     = 1'b0;
        test_reset();
        test_reset_mid_sweep();
        test_first_take();
        test_playback_wrap();
        test_overrun();
        test_delete();
        test_delete_inactive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
